relay_mux_sequencer: RTL and testbench

- Break-before-make controller for a bank of N relay instances (Relais-style, coil-driven switches) that share one common analog node.
- Accepts channel-select requests over a valid/ready handshake and guarantees no two coils are ever energised together.
- Times contact break and settle intervals, then reports completion.
- Sits in the mixed-signal testbench layer that drives the nonlinear switch/relay library models from digital control.

---
 rtl/relay_mux_sequencer.sv | 163 ++++++++++++++++
 tb/tb_relay_mux_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/relay_mux_sequencer.sv
// Break-before-make sequencer for N coil-driven relays sharing one analog node.
// Optional hold watchdog: define RELAY_SEQ_HOLD_WATCHDOG_EN.
module relay_mux_sequencer #(
  parameter int N             = 4,
  parameter int SEL_W         = 2,
  parameter int CNT_W         = 8,
  parameter int BREAK_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int HOLD_MAX      = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_open,
  output logic [N-1:0]     coil,
  output logic             active_valid,
  output logic [SEL_W-1:0] active_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, BREAK, MAKE, SETTLE, DONE} state_t;

  localparam logic [SEL_W:0] NUM_CH = (SEL_W+1)'(N);
  localparam logic [N-1:0]   ONE    = N'(1);

  if (HOLD_MAX < 1 || BREAK_CYCLES < 1 || SETTLE_CYCLES < 1 ||
      BREAK_CYCLES >= (1 << CNT_W) || SETTLE_CYCLES >= (1 << CNT_W) ||
      (1 << SEL_W) < N) begin : g_cfg_check
    $error("relay_mux_sequencer: illegal parameter set");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_q, sel_n, asel_n;
  logic             open_q, open_n;
  logic [N-1:0]     coil_n;
  logic             av_n, busy_n, done_n, err_n, to_n;
  logic             accept, wd_fire;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef RELAY_SEQ_HOLD_WATCHDOG_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_cnt;

  // An accept on the same edge wins over the watchdog.
  assign wd_fire = (state == IDLE) && !accept && (coil != '0) &&
                   (hold_cnt == HW'(HOLD_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          hold_cnt <= '0;
    else if (accept || state != IDLE || coil == '0 || wd_fire) hold_cnt <= '0;
    else                                              hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    open_n  = open_q;
    coil_n  = coil;
    av_n    = active_valid;
    asel_n  = active_sel;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sel_n  = req_sel;
          open_n = req_open;
          if (!req_open && {1'b0, req_sel} >= NUM_CH) begin
            err_n = 1'b1;
          end else if ((req_open && coil == '0) ||
                       (!req_open && active_valid && req_sel == active_sel)) begin
            // Nothing to switch: report completion straight away.
            state_n = DONE;
            busy_n  = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n = BREAK;
            cnt_n   = CNT_W'(BREAK_CYCLES - 1);
            coil_n  = '0;
            av_n    = 1'b0;
            busy_n  = 1'b1;
          end
        end else if (wd_fire) begin
          coil_n = '0;
          av_n   = 1'b0;
          to_n   = 1'b1;
        end
      end
      BREAK: begin
        if (cnt == '0) state_n = MAKE;
        else           cnt_n   = cnt - 1'b1;
      end
      MAKE: begin
        if (open_q) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          coil_n  = ONE << sel_q;
          state_n = SETTLE;
          cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_n = DONE;
          av_n    = 1'b1;
          asel_n  = sel_q;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_q        <= '0;
      open_q       <= 1'b0;
      coil         <= '0;
      active_valid <= 1'b0;
      active_sel   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sel_q        <= sel_n;
      open_q       <= open_n;
      coil         <= coil_n;
      active_valid <= av_n;
      active_sel   <= asel_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      timeout      <= to_n;
    end
  end

endmodule

// File: tb/tb_relay_mux_sequencer.sv
// Scoreboard bench for relay_mux_sequencer: directed plan followed by randomized
// requests (held valid, churning select, occasional resets) against a channel-level model.
module tb_relay_mux_sequencer;
  localparam int N     = 4;
  localparam int SEL_W = 3;
  localparam int BRK   = 8;
  localparam int STL   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_open;
  logic [SEL_W-1:0] req_sel;
  logic [N-1:0]     coil;
  logic             active_valid, busy, done, err, timeout;
  logic [SEL_W-1:0] active_sel;

  relay_mux_sequencer #(.N(N), .SEL_W(SEL_W), .CNT_W(8), .BREAK_CYCLES(BRK),
                        .SETTLE_CYCLES(STL), .HOLD_MAX(200)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_open(req_open), .coil(coil),
    .active_valid(active_valid), .active_sel(active_sel), .busy(busy),
    .done(done), .err(err), .timeout(timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    int         at;
    logic [N-1:0] coil;
    bit         av;
    int         asel;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int closed = -1, m_asel = 0, last_done = -1, zero_run = 0;
  logic [N-1:0] last_nz = '0, prev_coil = '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int ch);
    logic [N-1:0] v;
    v = '0;
    if (ch >= 0) v[ch] = 1'b1;
    return v;
  endfunction

  task automatic push(input bit is_err, input int at);
    exp_t e;
    e.is_err = is_err;
    e.at     = at;
    e.coil   = onehot(closed);
    e.av     = (closed >= 0);
    e.asel   = m_asel;
    q.push_back(e);
  endtask

  // Monitor + reference model: channel-level view of what each accepted request must produce.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      closed = -1;
      m_asel = 0;
      chk("rst_coil", coil, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {done, err, timeout}, 0);
      chk("rst_active", {active_valid, active_sel}, 0);
    end else begin
      chk("onehot_coil", ($countones(coil) <= 1), 1);
      if (coil == '0) zero_run++;
      else if (prev_coil == '0) begin
        if (last_nz != '0 && coil != last_nz) chk("break_gap", (zero_run >= BRK), 1);
        last_nz  = coil;
        zero_run = 0;
      end
      prev_coil = coil;
`ifndef RELAY_SEQ_HOLD_WATCHDOG_EN
      chk("timeout_low", timeout, 0);
`endif
      if (done || err) begin
        if (q.size() == 0) chk("unexpected_pulse", {done, err}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {done, err}, e.is_err ? 1 : 2);
          chk("pulse_cycle", cyc, e.at);
          chk("coil_at_pulse", coil, e.coil);
          chk("active_valid_at_pulse", active_valid, e.av);
          chk("active_sel_at_pulse", active_sel, e.asel);
          if (!e.is_err) last_done = cyc;
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        chk("missing_pulse", cyc, q[0].at);
        void'(q.pop_front());
      end
      chk("ready_state", req_ready, (q.size() == 0 && cyc > last_done));
      chk("busy_state", busy, !(q.size() == 0 && cyc > last_done));
      if (req_valid && req_ready) begin
        int e0;
        e0 = cyc + 1;
        if (req_open) begin
          if (closed < 0) push(1'b0, e0);
          else begin
            closed = -1;
            push(1'b0, e0 + BRK + 1);
          end
        end else if (int'(req_sel) >= N) push(1'b1, e0);
        else if (int'(req_sel) == closed) push(1'b0, e0);
        else begin
          closed = int'(req_sel);
          m_asel = int'(req_sel);
          push(1'b0, e0 + BRK + STL + 1);
        end
      end
    end
  end

  task automatic issue(input bit op, input int sel, input bit wait_end);
    int sv;
    bit got;
    sv = sel;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_open  = op;
    req_sel   = sv[SEL_W-1:0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_sel   = SEL_W'($urandom_range(0, 7));
    if (wait_end) begin
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (q.size() == 0) begin got = 1'b1; break; end
      end
      if (!got) chk("sequence_timeout", 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_open = 1'b0; req_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0, 2, 1'b1);   // close ch2
    issue(1'b0, 1, 1'b1);   // move to ch1
    issue(1'b0, 1, 1'b1);   // same channel
    issue(1'b0, 5, 1'b1);   // invalid select
    issue(1'b0, 3, 1'b1);
    issue(1'b1, 0, 1'b1);   // open all
    issue(1'b1, 0, 1'b1);   // open when already open
    issue(1'b0, 2, 1'b0);   // reset lands mid-SETTLE
    repeat (14) @(posedge clk);
    chk("pre_reset_coil", coil, 4);
    #2 rst = 1'b1;
    #1 chk("async_coil_drop", coil, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end else begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_open  = ($urandom_range(0, 5) == 0);
        req_sel   = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(4, 7))
                                                : SEL_W'($urandom_range(0, 3));
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
